histogram_readout: RTL and testbench

- Sweeps port B of the histogram dual memory bin by bin and streams each bin's count out on a valid/ready interface.
- Optionally clears each bin after it is read, so one sweep both drains and resets the histogram while port A keeps accumulating radiation hits.
- It is the reading end of the histogram memory and replaces the manual AXI address-poke readout with a hardware drain.

---
 rtl/histogram_readout_if.sv | 14 +
 rtl/histogram_readout.sv | 102 ++++++++++
 tb/tb_histogram_readout.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/histogram_readout_if.sv
// histogram_readout_if: bin stream carrying one histogram bin per valid/ready beat.
interface histogram_readout_if #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    logic binValid;
    logic binReady;
    logic [ADDRESS_WIDTH-1:0] binAddress;
    logic [DATA_WIDTH-1:0] binCount;
    logic binCollision;

    modport master(output binValid, binAddress, binCount, binCollision, input binReady);
    modport slave(input binValid, binAddress, binCount, binCollision, output binReady);
endinterface

// File: rtl/histogram_readout.sv
// histogram_readout: sweeps histogram port B bin by bin, streams each count and optionally clears it.
module histogram_readout #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int SUM_WIDTH = ADDRESS_WIDTH + DATA_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clearOnRead,
    output logic busy,
    output logic done,
    output logic [ADDRESS_WIDTH-1:0] memAddressB,
    output logic memWriteB,
    output logic [DATA_WIDTH-1:0] memDataInB,
    input  logic [DATA_WIDTH-1:0] memDataOutB,
    input  logic accumWrite,
    input  logic [ADDRESS_WIDTH-1:0] accumAddress,
    histogram_readout_if.master stream,
    output logic [SUM_WIDTH-1:0] sweepTotal,
    output logic [15:0] collisionCount
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, OFFER, CLEAR, NEXT, DONE} stateType;
    stateType state;
    logic [ADDRESS_WIDTH-1:0] binIdx, binAddress;
    logic [DATA_WIDTH-1:0] binCount;
    logic binValid, collisionFlag, clearLatched, hitNow, collided;

    assign hitNow = accumWrite && accumAddress == binIdx;
    // Live during OFFER so a hit landing in the handshake cycle is still reported and spares the bin.
    assign collided = collisionFlag || (state == OFFER && hitNow);
    assign memDataInB = '0;
    assign stream.binValid = binValid;
    assign stream.binAddress = binAddress;
    assign stream.binCount = binCount;
    assign stream.binCollision = collided;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            binIdx <= '0;
            binAddress <= '0;
            binCount <= '0;
            binValid <= 1'b0;
            collisionFlag <= 1'b0;
            clearLatched <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            memAddressB <= '0;
            memWriteB <= 1'b0;
            sweepTotal <= '0;
            collisionCount <= '0;
        end else begin
            done <= 1'b0;
            memWriteB <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    clearLatched <= clearOnRead;
                    sweepTotal <= '0;
                    collisionCount <= '0;
                    binIdx <= '0;
                    memAddressB <= '0;
                    busy <= 1'b1;
                    state <= READ;
                end
                READ: begin
                    collisionFlag <= hitNow;
                    state <= WAIT;
                end
                WAIT: begin
                    collisionFlag <= collisionFlag || hitNow;
                    binCount <= memDataOutB;
                    binAddress <= binIdx;
                    binValid <= 1'b1;
                    state <= OFFER;
                end
                OFFER: begin
                    collisionFlag <= collided;
                    if (stream.binReady) begin
                        binValid <= 1'b0;
                        sweepTotal <= sweepTotal + SUM_WIDTH'(binCount);
                        if (collided && !(&collisionCount)) collisionCount <= collisionCount + 16'd1;
                        memWriteB <= clearLatched && !collided;
                        state <= clearLatched ? CLEAR : NEXT;
                    end
                end
                CLEAR: state <= NEXT;
                NEXT: if (&binIdx) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    state <= DONE;
                end else begin
                    binIdx <= binIdx + 1'b1;
                    memAddressB <= binIdx + 1'b1;
                    state <= READ;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_histogram_readout.sv
// tb_histogram_readout: directed sweeps with random data and ready patterns against a dual-port memory model.
module tb_histogram_readout;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int SW = AW + DW;
    localparam int NB = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic clearOnRead = 1'b0;
    logic accumWrite = 1'b0;
    logic [AW-1:0] accumAddress = '0;
    logic busy, done, memWriteB;
    logic [AW-1:0] memAddressB;
    logic [DW-1:0] memDataInB, memDataOutB;
    logic [SW-1:0] sweepTotal;
    logic [15:0] collisionCount;

    histogram_readout_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) stream();

    histogram_readout #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .clearOnRead(clearOnRead),
        .busy(busy), .done(done), .memAddressB(memAddressB), .memWriteB(memWriteB),
        .memDataInB(memDataInB), .memDataOutB(memDataOutB), .accumWrite(accumWrite),
        .accumAddress(accumAddress), .stream(stream), .sweepTotal(sweepTotal),
        .collisionCount(collisionCount)
    );

    always #5 clk = ~clk;

    // Histogram dual-port memory: port B 1-cycle read plus write, port A increments.
    logic [DW-1:0] mem [NB];
    logic [DW-1:0] preload [NB];
    logic loadReq = 1'b0;
    always @(posedge clk) begin
        if (loadReq) begin
            for (int i = 0; i < NB; i++) mem[i] <= preload[i];
        end else begin
            memDataOutB <= mem[memAddressB];
            if (memWriteB) mem[memAddressB] <= memDataInB;
            if (accumWrite) mem[accumAddress] <= mem[accumAddress] + 1'b1;
        end
    end

    int readyMode = 0;
    int cyc = 0;
    initial begin
        stream.binReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            stream.binReady = readyMode == 0 ? 1'b1 : readyMode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(1, 0));
        end
    end

    logic [AW-1:0] beatA [$];
    logic [DW-1:0] beatC [$];
    logic beatK [$];
    int doneCount = 0;
    int stallChanges = 0;
    logic held = 1'b0;
    logic [AW-1:0] holdA;
    logic [DW-1:0] holdC;
    initial forever begin
        @(negedge clk);
        if (done) doneCount++;
        if (stream.binValid) begin
            if (held && (stream.binAddress !== holdA || stream.binCount !== holdC)) stallChanges++;
            if (stream.binReady) begin
                beatA.push_back(stream.binAddress);
                beatC.push_back(stream.binCount);
                beatK.push_back(stream.binCollision);
                held = 1'b0;
            end else begin
                held = 1'b1;
                holdA = stream.binAddress;
                holdC = stream.binCount;
            end
        end else held = 1'b0;
    end

    int errors = 0;
    int checks = 0;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic loadMem();
        @(posedge clk);
        #1 loadReq = 1'b1;
        @(posedge clk);
        #1 loadReq = 1'b0;
    endtask

    task automatic startSweep(input logic clr);
        @(posedge clk);
        #1 start = 1'b1;
        clearOnRead = clr;
        @(posedge clk);
        #1 start = 1'b0;
        clearOnRead = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20000);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    task automatic waitAddr(input string tag, input int addr, input logic needWrite);
        int n = 0;
        while (!(memAddressB == AW'(addr) && (!needWrite || memWriteB)) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reach"}, 64'(memAddressB), 64'(addr));
    endtask

    task automatic checkSweep(input string tag, input logic [DW-1:0] snap [NB], input int base,
                              input logic clr, input int collBin);
        longint sum = 0;
        int memBad = 0;
        logic [DW-1:0] expMem;
        check({tag, "_beats"}, 64'(beatA.size() - base), 64'(NB));
        for (int i = 0; i < NB && base + i < beatA.size(); i++) begin
            check({tag, "_beat"}, {32'(beatA[base+i]), 16'(beatC[base+i]), 16'(beatK[base+i])},
                  {32'(i), 16'(snap[i]), 16'(i == collBin)});
            sum += longint'(snap[i]);
        end
        check({tag, "_total"}, 64'(sweepTotal), 64'(sum));
        check({tag, "_collisions"}, 64'(collisionCount), 64'(collBin >= 0));
        for (int i = 0; i < NB; i++) begin
            expMem = i == collBin ? snap[i] + 1'b1 : clr ? '0 : snap[i];
            if (mem[i] !== expMem) memBad++;
        end
        check({tag, "_mem_bad_bins"}, 64'(memBad), 64'd0);
    endtask

    logic [DW-1:0] snap [NB];
    int base, d0, s0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_write", 64'(memWriteB), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_outputs", {32'(sweepTotal), 16'(collisionCount), 6'(memAddressB), 10'(stream.binAddress)}, 64'd0);
        check("rst_stream", {16'(stream.binCount), 3'(stream.binValid), 3'(stream.binCollision), 3'(done), 3'(busy)}, 64'd0);

        // Sweep reading address-valued bins without clearing.
        for (int i = 0; i < NB; i++) preload[i] = DW'(i);
        snap = preload;
        loadMem();
        base = beatA.size();
        d0 = doneCount;
        startSweep(1'b0);
        check("busy_after_start", 64'(busy), 64'd1);
        waitDone("s1");
        checkSweep("s1", snap, base, 1'b0, -1);
        check("s1_total_const", 64'(sweepTotal), 64'd523776);
        repeat (5) @(negedge clk);
        check("s1_done_pulses", 64'(doneCount - d0), 64'd1);

        // Same bins with clear-on-read, then a sweep of the emptied histogram.
        base = beatA.size();
        startSweep(1'b1);
        waitDone("s2");
        checkSweep("s2", snap, base, 1'b1, -1);
        for (int i = 0; i < NB; i++) snap[i] = '0;
        base = beatA.size();
        startSweep(1'b1);
        waitDone("s3");
        checkSweep("s3", snap, base, 1'b1, -1);

        // Throttled consumer: bin 5 saturated, ready one cycle in three.
        for (int i = 0; i < NB; i++) preload[i] = DW'(i);
        preload[5] = 16'hFFFF;
        snap = preload;
        loadMem();
        readyMode = 1;
        base = beatA.size();
        s0 = stallChanges;
        startSweep(1'b0);
        waitDone("stall");
        checkSweep("stall", snap, base, 1'b0, -1);
        check("stall_stable", 64'(stallChanges - s0), 64'd0);

        // Random counts, random ready, random clear mode.
        for (int i = 0; i < NB; i++) preload[i] = DW'($urandom);
        snap = preload;
        loadMem();
        readyMode = 2;
        base = beatA.size();
        s0 = stallChanges;
        begin
            logic clr = 1'($urandom_range(1, 0));
            startSweep(clr);
            waitDone("rand");
            checkSweep("rand", snap, base, clr, -1);
        end
        check("rand_stable", 64'(stallChanges - s0), 64'd0);

        // Port A hit on bin 7 while its read is in flight.
        for (int i = 0; i < NB; i++) preload[i] = DW'($urandom_range(1000, 1));
        snap = preload;
        loadMem();
        readyMode = 0;
        base = beatA.size();
        startSweep(1'b1);
        waitAddr("coll", 7, 1'b0);
        @(posedge clk);
        #1 accumWrite = 1'b1;
        accumAddress = AW'(7);
        @(posedge clk);
        #1 accumWrite = 1'b0;
        waitDone("coll");
        checkSweep("coll", snap, base, 1'b1, 7);

        // Reset arrives while bin 300 is being cleared.
        for (int i = 0; i < NB; i++) preload[i] = DW'(i);
        loadMem();
        startSweep(1'b1);
        waitAddr("mid_rst", 300, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_write", 64'(memWriteB), 64'd0);
        check("mid_rst_outputs", {32'(sweepTotal), 16'(collisionCount), 6'(memAddressB), 10'(stream.binAddress)}, 64'd0);
        check("mid_rst_stream", {16'(stream.binCount), 3'(stream.binValid), 3'(stream.binCollision), 3'(done), 3'(busy)}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < NB; i++) snap[i] = i < 300 ? '0 : DW'(i);
        base = beatA.size();
        startSweep(1'b0);
        waitDone("resweep");
        checkSweep("resweep", snap, base, 1'b0, -1);

        // A second start in the middle of bin 10 must not restart or retarget the sweep.
        for (int i = 0; i < NB; i++) preload[i] = DW'(i);
        snap = preload;
        loadMem();
        base = beatA.size();
        d0 = doneCount;
        startSweep(1'b0);
        waitAddr("restart", 10, 1'b0);
        @(posedge clk);
        #1 start = 1'b1;
        clearOnRead = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        clearOnRead = 1'b0;
        waitDone("restart");
        checkSweep("restart", snap, base, 1'b0, -1);
        repeat (20) @(negedge clk);
        check("restart_done_pulses", 64'(doneCount - d0), 64'd1);
        check("restart_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
